// File: rtl/btn_cond_pkg.sv
// Shared constants and helpers for the button conditioning block.
// Sample-rate presets and the debounce action encoding live here.
package btn_cond_pkg;

  localparam int BTN_PRESC_SIM  = 1;
  localparam int BTN_PRESC_FPGA = 10000;
  localparam int BTN_STABLE_DEF = 4;

  // What a single bit's debounce counter does on a given cycle.
  typedef enum logic [1:0] {
    DEB_HOLD  = 2'd0,
    DEB_CLEAR = 2'd1,
    DEB_COUNT = 2'd2,
    DEB_FLIP  = 2'd3
  } deb_act_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_deb_bit.sv
// One input bit: 2-FF synchroniser, tick-gated debounce counter,
// registered edge pulses and a CPU-clearable press latch.
module btn_deb_bit
  import btn_cond_pkg::*;
#(
  parameter int STABLE = BTN_STABLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_in,
  input  logic clr,
  output logic btn_out,
  output logic btn_rise,
  output logic btn_fall,
  output logic press_latch
);

  localparam int CW = width_for(STABLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic          s1;
  logic          s2;
  logic          out_d;
  logic [CW-1:0] cnt;
  deb_act_t      act;

  // Any matching sample restarts the run, so a glitch cannot shorten it.
  always_comb begin
    act = DEB_HOLD;
    if (tick) begin
      if (s2 == btn_out) begin
        act = DEB_CLEAR;
      end else if (cnt == CNT_LAST) begin
        act = DEB_FLIP;
      end else begin
        act = DEB_COUNT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      cnt         <= '0;
      btn_out     <= 1'b0;
      out_d       <= 1'b0;
      btn_rise    <= 1'b0;
      btn_fall    <= 1'b0;
      press_latch <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      case (act)
        DEB_CLEAR: cnt <= '0;
        DEB_COUNT: cnt <= cnt + CW'(1);
        DEB_FLIP: begin
          btn_out <= s2;
          cnt     <= '0;
        end
        default: ;
      endcase
      out_d    <= btn_out;
      btn_rise <= btn_out & ~out_d;
      btn_fall <= ~btn_out & out_d;
      // A rise landing together with clr still sets the latch.
      press_latch <= (press_latch & ~clr) | btn_rise;
    end
  end

endmodule

// File: rtl/btn_cond.sv
// Button/switch conditioning ahead of comp's PORTI/PORTJ: a shared
// sample prescaler feeding WIDTH independent debounce bits.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PRESC  = BTN_PRESC_FPGA,
  parameter int STABLE = BTN_STABLE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall,
  output logic [WIDTH-1:0] press_latch,
  output logic             tick
);

  localparam int PW = width_for(PRESC);
  localparam logic [PW-1:0] PC_LAST = PW'(PRESC - 1);

  logic [PW-1:0] pc;
  logic [PW-1:0] pc_next;

  always_comb begin
    pc_next = (pc == PC_LAST) ? '0 : pc + PW'(1);
  end

  // tick is registered so it lines up with the cycle where pc == PRESC-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= '0;
      tick <= 1'b0;
    end else begin
      pc   <= pc_next;
      tick <= (pc_next == PC_LAST);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    btn_deb_bit #(
      .STABLE(STABLE)
    ) u_bit (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .btn_in      (btn_in[g]),
      .clr         (clr[g]),
      .btn_out     (btn_out[g]),
      .btn_rise    (btn_rise[g]),
      .btn_fall    (btn_fall[g]),
      .press_latch (press_latch[g])
    );
  end

endmodule

// File: tb/tb_btn_cond.sv
// Bench for btn_cond: a PRESC=1 and a PRESC=5 instance share stimulus and
// are checked against a streak-counting reference model every cycle.
module tb_btn_cond;

  localparam int STABLE = 4;

  logic        clk;
  logic        reset;
  logic [31:0] btn_in;
  logic [31:0] clr;

  logic [31:0] f_out, f_rise, f_fall, f_latch;
  logic        f_tick;
  logic [31:0] s_out, s_rise, s_fall, s_latch;
  logic        s_tick;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];

  btn_cond #(.WIDTH(32), .PRESC(1), .STABLE(STABLE)) dut_fast (
    .clk(clk), .reset(reset), .btn_in(btn_in), .clr(clr),
    .btn_out(f_out), .btn_rise(f_rise), .btn_fall(f_fall),
    .press_latch(f_latch), .tick(f_tick)
  );

  btn_cond #(.WIDTH(32), .PRESC(5), .STABLE(STABLE)) dut_slow (
    .clk(clk), .reset(reset), .btn_in(btn_in), .clr(clr),
    .btn_out(s_out), .btn_rise(s_rise), .btn_fall(s_fall),
    .press_latch(s_latch), .tick(s_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = PRESC 1, index 1 = PRESC 5.
  logic [31:0] m_s1[2], m_s2[2], m_out[2], m_out_d[2];
  logic [31:0] m_rise[2], m_fall[2], m_latch[2];
  logic        m_tick[2];
  int          m_n[2];
  int          m_run[2][32];
  logic [31:0] nxt_out, old_rise;
  int          period;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_s1[d] = '0; m_s2[d] = '0; m_out[d] = '0; m_out_d[d] = '0;
        m_rise[d] = '0; m_fall[d] = '0; m_latch[d] = '0;
        m_tick[d] = 1'b0; m_n[d] = 0;
        for (int b = 0; b < 32; b++) m_run[d][b] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        period  = (d == 0) ? 1 : 5;
        nxt_out = m_out[d];
        // Level follows the synced input once STABLE sampled ticks in a row disagree.
        if (m_tick[d]) begin
          for (int b = 0; b < 32; b++) begin
            if (m_s2[d][b] == m_out[d][b]) begin
              m_run[d][b] = 0;
            end else begin
              m_run[d][b] = m_run[d][b] + 1;
              if (m_run[d][b] == STABLE) begin
                nxt_out[b]  = m_s2[d][b];
                m_run[d][b] = 0;
              end
            end
          end
        end
        old_rise   = m_rise[d];
        m_rise[d]  = m_out[d] & ~m_out_d[d];
        m_fall[d]  = ~m_out[d] & m_out_d[d];
        m_latch[d] = (m_latch[d] & ~clr) | old_rise;
        if (d == 0 && m_rise[0] != 0) exp_q.push_back(m_rise[0]);
        m_out_d[d] = m_out[d];
        m_out[d]   = nxt_out;
        m_s2[d]    = m_s1[d];
        m_s1[d]    = btn_in;
        m_n[d]     = m_n[d] + 1;
        m_tick[d]  = ((m_n[d] % period) == period - 1);
      end
    end
  end

  // driver / scenario tasks
  task automatic test_reset();
    reset  = 1'b0;
    btn_in = '1;
    clr    = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_in = ~btn_in;
      compared++;
      if ({f_out, f_rise, f_fall, f_latch, f_tick, s_out, s_rise, s_fall, s_latch, s_tick} !== '0) begin
        mismatched++;
        $display("FAIL reset_hold cyc %0d: got fast %h/%b slow %h/%b, exp all zero", i, f_out, f_tick, s_out, s_tick);
      end
    end
    btn_in = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (f_tick !== 1'b1) begin
      mismatched++;
      $display("FAIL tick_first_fast: got %b exp 1", f_tick);
    end
    compared++;
    if (s_tick !== 1'b0) begin
      mismatched++;
      $display("FAIL tick_first_slow: got %b exp 0", s_tick);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if ({f_out, f_rise, f_fall, f_latch, f_tick} !== {m_out[0], m_rise[0], m_fall[0], m_latch[0], m_tick[0]}) begin
        mismatched++;
        $display("FAIL reset_idle_fast cyc %0d: got %h exp %h", i, {f_out, f_rise, f_fall, f_latch, f_tick}, {m_out[0], m_rise[0], m_fall[0], m_latch[0], m_tick[0]});
      end
      compared++;
      if ({s_out, s_rise, s_fall, s_latch, s_tick} !== {m_out[1], m_rise[1], m_fall[1], m_latch[1], m_tick[1]}) begin
        mismatched++;
        $display("FAIL reset_idle_slow cyc %0d: got %h exp %h", i, {s_out, s_rise, s_fall, s_latch, s_tick}, {m_out[1], m_rise[1], m_fall[1], m_latch[1], m_tick[1]});
      end
    end
  endtask

  task automatic test_press();
    btn_in[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      compared++;
      if ({f_out[2], f_rise[2], f_latch[2]} !== {1'(i >= 5), 1'(i == 6), 1'(i >= 7)}) begin
        mismatched++;
        $display("FAIL press_bit2 edge %0d: got out/rise/latch %b%b%b exp %b%b%b", i, f_out[2], f_rise[2], f_latch[2], i >= 5, i == 6, i >= 7);
      end
      compared++;
      if ({f_out, f_rise, f_fall, f_latch, f_tick} !== {m_out[0], m_rise[0], m_fall[0], m_latch[0], m_tick[0]}) begin
        mismatched++;
        $display("FAIL press_fast edge %0d: got %h exp %h", i, {f_out, f_rise, f_fall, f_latch, f_tick}, {m_out[0], m_rise[0], m_fall[0], m_latch[0], m_tick[0]});
      end
    end
  endtask

  task automatic test_bounce();
    int pat[5] = '{1, 0, 1, 1, 0};
    for (int i = 0; i < 16; i++) begin
      btn_in[0] = (i < 5) ? 1'(pat[i]) : 1'b1;
      @(negedge clk);
      compared++;
      if (f_out[0] !== 1'(i >= 10)) begin
        mismatched++;
        $display("FAIL bounce_bit0 edge %0d: got %b exp %b", i, f_out[0], i >= 10);
      end
      compared++;
      if ({s_out, s_rise, s_fall, s_latch, s_tick} !== {m_out[1], m_rise[1], m_fall[1], m_latch[1], m_tick[1]}) begin
        mismatched++;
        $display("FAIL bounce_slow edge %0d: got %h exp %h", i, {s_out, s_rise, s_fall, s_latch, s_tick}, {m_out[1], m_rise[1], m_fall[1], m_latch[1], m_tick[1]});
      end
    end
  endtask

  task automatic test_release_clear();
    btn_in[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if ({f_out[2], f_fall[2], f_latch[2]} !== {1'(i < 5), 1'(i == 6), 1'b1}) begin
        mismatched++;
        $display("FAIL release_bit2 edge %0d: got out/fall/latch %b%b%b exp %b%b1", i, f_out[2], f_fall[2], f_latch[2], i < 5, i == 6);
      end
    end
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    compared++;
    if (f_latch[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_bit2: got %b exp 0", f_latch[2]);
    end
    btn_in[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if ({f_rise[3], f_latch[3]} !== {1'(i == 6), 1'(i >= 7)}) begin
        mismatched++;
        $display("FAIL clr_vs_rise_bit3 edge %0d: got rise/latch %b%b exp %b%b", i, f_rise[3], f_latch[3], i == 6, i >= 7);
      end
      clr[3] = (i == 6);
    end
    clr[3] = 1'b0;
  endtask

  task automatic test_presc();
    int ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ticks += int'(s_tick);
    end
    compared++;
    if (ticks != 4) begin
      mismatched++;
      $display("FAIL presc_tick_count: got %0d exp 4", ticks);
    end
    btn_in[5] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i < 16 || i >= 26) begin
        compared++;
        if (s_out[5] !== 1'(i >= 26)) begin
          mismatched++;
          $display("FAIL presc_steady_bit5 edge %0d: got %b exp %b", i, s_out[5], i >= 26);
        end
      end
      compared++;
      if ({s_out, s_rise, s_fall, s_latch, s_tick} !== {m_out[1], m_rise[1], m_fall[1], m_latch[1], m_tick[1]}) begin
        mismatched++;
        $display("FAIL presc_slow edge %0d: got %h exp %h", i, {s_out, s_rise, s_fall, s_latch, s_tick}, {m_out[1], m_rise[1], m_fall[1], m_latch[1], m_tick[1]});
      end
    end
    for (int i = 0; i < 40; i++) begin
      btn_in[6] = (i < 4);
      @(negedge clk);
      compared++;
      if (s_out[6] !== 1'b0) begin
        mismatched++;
        $display("FAIL presc_pulse_bit6 edge %0d: got %b exp 0", i, s_out[6]);
      end
    end
  endtask

  task automatic test_reset_mid();
    btn_in[7] = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    compared++;
    if (f_out[7] !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_before_reset: got %b exp 0", f_out[7]);
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({f_out, f_latch, s_out, s_latch} !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_clear: got fast %h/%h slow %h/%h exp zero", f_out, f_latch, s_out, s_latch);
    end
    reset = 1'b1;
    for (int i = 1; i < 11; i++) begin
      @(negedge clk);
      compared++;
      if (f_out[7] !== 1'(i >= 6)) begin
        mismatched++;
        $display("FAIL mid_rebuild_bit7 edge %0d: got %b exp %b", i, f_out[7], i >= 6);
      end
      compared++;
      if ({f_out, f_rise, f_fall, f_latch, f_tick} !== {m_out[0], m_rise[0], m_fall[0], m_latch[0], m_tick[0]}) begin
        mismatched++;
        $display("FAIL mid_fast edge %0d: got %h exp %h", i, {f_out, f_rise, f_fall, f_latch, f_tick}, {m_out[0], m_rise[0], m_fall[0], m_latch[0], m_tick[0]});
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] want;
    exp_q.delete();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) btn_in = btn_in ^ ($urandom & $urandom & $urandom);
      clr = $urandom & $urandom & $urandom;
      @(negedge clk);
      compared++;
      if ({f_out, f_rise, f_fall, f_latch, f_tick} !== {m_out[0], m_rise[0], m_fall[0], m_latch[0], m_tick[0]}) begin
        mismatched++;
        $display("FAIL random_fast cyc %0d: got %h exp %h", i, {f_out, f_rise, f_fall, f_latch, f_tick}, {m_out[0], m_rise[0], m_fall[0], m_latch[0], m_tick[0]});
      end
      compared++;
      if ({s_out, s_rise, s_fall, s_latch, s_tick} !== {m_out[1], m_rise[1], m_fall[1], m_latch[1], m_tick[1]}) begin
        mismatched++;
        $display("FAIL random_slow cyc %0d: got %h exp %h", i, {s_out, s_rise, s_fall, s_latch, s_tick}, {m_out[1], m_rise[1], m_fall[1], m_latch[1], m_tick[1]});
      end
      if (f_rise != 0) begin
        compared++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        if (f_rise !== want) begin
          mismatched++;
          $display("FAIL random_rise_sb cyc %0d: got %h exp %h", i, f_rise, want);
        end
      end
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL random_rise_left: got %0d pending exp 0", exp_q.size());
    end
    clr = '0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release_clear();
    test_presc();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
